decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised instruction-decode stage with an ID/EX pipeline register. It holds the register file, a write-through bypass from WB and a 3-way operand forwarding mux. It also resolves branches and jumps in ID, detects load-use hazards internally, and supports hold, flush and bubble insertion. It sits between the IF/ID register and the execute stage and replaces the fixed-width decode/ID-EX block.

## Interface
- DATA_W, 32, datapath width (≥32; immediates sign-extended to DATA_W)
- NREG, 32, architectural registers; AW = $clog2(NREG)
- IMM_W, 16, immediate field width
- Clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  external hold: ID/EX register keeps its value
- flush  in  1  squash ID: next EX is a bubble
- ir_id  in  32  instruction in ID
- pc4_id  in  DATA_W  PC+4 of instruction in ID
- wb_we, wb_addr, wb_data  in  1/AW/DATA_W  register-file write port
- fwd_sel_x, fwd_sel_y  in  2  per-operand source: 0 regfile, 1 fwd_exm, 2 fwd_mwb, 3 reserved (= 0)
- fwd_exm, fwd_mwb  in  DATA_W  forwarded results from EX/MEM and MEM/WB
- rs_id, rt_id  out  AW  decoded source addresses (jal forces rs to NREG-1)
- load_use_stall  out  1  request to freeze PC and IF/ID
- br_taken_id, jump_id, jr_id  out  1  redirect requests
- br_target_id, jr_target_id  out  DATA_W  redirect addresses
- ctrl_ex  out  ctrl_t  packed EX/MEM/WB control bundle
- valid_ex  out  1  EX slot holds a real instruction
- x_ex, y_ex, imm_ex, pc4_ex  out  DATA_W  operands, sign-extended immediate, link PC
- rt_ex, rd_ex  out  AW  destination candidates

## Operation
- **Decode.** Decoding is combinational from `ir_id` via `decode_pkg::decode()`. Unknown opcodes give an all-zero ctrl_t, which is a NOP.
- **Register reads.** Two asynchronous read ports.
  - Register 0 always reads 0. Writes to register 0 are ignored.
  - Write-through: if wb_we && wb_addr == read address != 0, the read returns wb_data in the same cycle.
- **Forwarding.** Operand X/Y is selected by fwd_sel_x/y after the regfile read. The forwarded values feed the branch compare, jr_target_id and the EX register.
- **Branch.**
  - br_taken_id = beq & (X == Y) | bne & (X != Y).
  - br_target_id = pc4_id + (sext(imm) << 2).
- **Jump.** jr_target_id = forwarded X.
- **Load-use detection.** load_use_stall = valid_ex & ctrl_ex.mem_read & rt_ex != 0 & (rt_ex == rs_id | (rt_ex == rt_id & instr uses rt)).
- **ID/EX update priority** (highest first):
  1. reset
  2. stall: hold all fields
  3. flush or load_use_stall: bubble (valid_ex=0, ctrl_ex=0, data fields don't-care but set to 0)
  4. load: register the decoded instruction, valid_ex=1
- **Redirect gating.** br_taken_id, jump_id and jr_id are forced to 0 while load_use_stall or flush is 1. This prevents redirecting on stale operands.

## Timing
- **Reset.** All ID/EX outputs are 0, including valid_ex and ctrl_ex. Regfile contents are 0. Combinational outputs follow their inputs.
- **Latency.** One cycle from ID inputs to EX outputs. Redirect outputs and load_use_stall are combinational in the same cycle.
- **Regfile write timing.** Writes commit at posedge Clk. A same-cycle read sees the new value through the bypass.
- **Load-use stall duration.** Exactly one cycle per load-use pair. In the next cycle the bubble is in EX, so the stall deasserts.
- **stall and load_use_stall together.** stall wins and the register holds. The hazard is re-evaluated the next cycle.
- **Reset mid-operation.** Asynchronous clear of all registers. No pending state survives.

## Configuration
- **DECODE_BNE_EN defined:** bne is decoded and uses the inequality compare.
- **DECODE_BNE_EN undefined:** the bne opcode decodes as NOP and br_taken_id depends on beq only.

## Structure
- **decode_pkg:** opcode/funct constants, alu_op_t enum (4-bit), ctrl_t struct and the decode() function.
- **reg_file sub-module:** parameters DATA_W and NREG, 2R1W, with bypass inside.

## Test plan
- **Reset:** assert rst_n=0 mid-run → all EX outputs 0 and valid_ex=0 immediately, without waiting for a clock edge.
- **Write-through:** wb_we=1, wb_addr=5, wb_data=0xDEAD_BEEF; same cycle ir_id=add $1,$5,$0 → x_ex=0xDEADBEEF after the edge. Write to r0 → r0 still reads 0.
- **Load-use:** lw $2,0($3) followed by add $4,$2,$2 → load_use_stall=1 for one cycle, then valid_ex=0 bubble, then add enters EX with x_ex taken from fwd_mwb when fwd_sel_x=2.
- **Branch:** beq with X=Y=7 and imm=-2 (pc4_id=0x100) → br_taken_id=1 and br_target_id=0xF8. bne with the same operands → 0 (DECODE_BNE_EN defined) or NOP (undefined).
- **Priority:** stall=1 together with flush=1 → EX fields unchanged. flush=1 alone → valid_ex=0 and ctrl_ex=0.
- **jal/jr:** jal → rs_id=31 and pc4_ex=pc4_id. jr $7 with fwd_sel_x=1 and fwd_exm=0x400 → jr_id=1 and jr_target_id=0x400.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// decode_pkg: opcode/funct encodings, ALU op enum, control bundle and the decoder.
// Build option DECODE_BNE_EN: when defined, bne is decoded; otherwise it decodes as NOP.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [3:0] {
        ALU_NOP = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_SLT = 4'd5
    } alu_op_t;

    // EX/MEM/WB control bundle; all-zero is a NOP.
    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        logic    link;
        logic    branch;
        logic    branch_ne;
        logic    jump;
        logic    jump_reg;
        logic    uses_rt;
        alu_op_t alu_op;
    } ctrl_t;

    // Opcode/funct to control bundle; anything unrecognised yields all-zero.
    function automatic ctrl_t decode(input logic [5:0] opcode, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.uses_rt   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    FN_JR: begin
                        c          = '0;
                        c.jump_reg = 1'b1;
                    end
                    default: c = '0;
                endcase
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.uses_rt   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                c.branch  = 1'b1;
                c.uses_rt = 1'b1;
                c.alu_op  = ALU_SUB;
            end
            OP_BNE: begin
`ifdef DECODE_BNE_EN
                c.branch_ne = 1'b1;
                c.uses_rt   = 1'b1;
                c.alu_op    = ALU_SUB;
`else
                c = '0;
`endif
            end
            OP_J: begin
                c.jump = 1'b1;
            end
            OP_JAL: begin
                c.jump      = 1'b1;
                c.link      = 1'b1;
                c.reg_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: ID-side inputs and ID/EX outputs of the decode stage.
interface decode_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
);
    localparam int unsigned AW = $clog2(NREG);

    logic              stall;
    logic              flush;
    logic [31:0]       ir_id;
    logic [DATA_W-1:0] pc4_id;
    logic              wb_we;
    logic [AW-1:0]     wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        fwd_sel_x;
    logic [1:0]        fwd_sel_y;
    logic [DATA_W-1:0] fwd_exm;
    logic [DATA_W-1:0] fwd_mwb;

    logic [AW-1:0]     rs_id;
    logic [AW-1:0]     rt_id;
    logic              load_use_stall;
    logic              br_taken_id;
    logic              jump_id;
    logic              jr_id;
    logic [DATA_W-1:0] br_target_id;
    logic [DATA_W-1:0] jr_target_id;
    decode_pkg::ctrl_t ctrl_ex;
    logic              valid_ex;
    logic [DATA_W-1:0] x_ex;
    logic [DATA_W-1:0] y_ex;
    logic [DATA_W-1:0] imm_ex;
    logic [DATA_W-1:0] pc4_ex;
    logic [AW-1:0]     rt_ex;
    logic [AW-1:0]     rd_ex;

    modport slave (
        input  stall, flush, ir_id, pc4_id, wb_we, wb_addr, wb_data,
               fwd_sel_x, fwd_sel_y, fwd_exm, fwd_mwb,
        output rs_id, rt_id, load_use_stall, br_taken_id, jump_id, jr_id,
               br_target_id, jr_target_id, ctrl_ex, valid_ex, x_ex, y_ex,
               imm_ex, pc4_ex, rt_ex, rd_ex
    );

    modport master (
        output stall, flush, ir_id, pc4_id, wb_we, wb_addr, wb_data,
               fwd_sel_x, fwd_sel_y, fwd_exm, fwd_mwb,
        input  rs_id, rt_id, load_use_stall, br_taken_id, jump_id, jr_id,
               br_target_id, jr_target_id, ctrl_ex, valid_ex, x_ex, y_ex,
               imm_ex, pc4_ex, rt_ex, rd_ex
    );
endinterface

// File: rtl/decode_stage_reg_file.sv
// reg_file: 2R1W register file, r0 hard-wired to zero, write-through from the write port.
module reg_file #(
    parameter  int unsigned DATA_W = 32,
    parameter  int unsigned NREG   = 32,
    localparam int unsigned AW     = $clog2(NREG)
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     raddr_x_i,
    input  logic [AW-1:0]     raddr_y_i,
    output logic [DATA_W-1:0] rdata_x_o,
    output logic [DATA_W-1:0] rdata_y_o,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);
    logic [DATA_W-1:0] mem_q [NREG];

    // Storage: cleared on reset, writes to r0 dropped.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port X with same-cycle bypass of the write port.
    always_comb begin
        rdata_x_o = mem_q[raddr_x_i];
        if (raddr_x_i == '0) begin
            rdata_x_o = '0;
        end else if (we_i && (waddr_i == raddr_x_i)) begin
            rdata_x_o = wdata_i;
        end
    end

    // Read port Y with same-cycle bypass of the write port.
    always_comb begin
        rdata_y_o = mem_q[raddr_y_i];
        if (raddr_y_i == '0) begin
            rdata_y_o = '0;
        end else if (we_i && (waddr_i == raddr_y_i)) begin
            rdata_y_o = wdata_i;
        end
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode, register read, forwarding, branch/jump resolution,
// load-use detection and the ID/EX pipeline register.
// Build option DECODE_BNE_EN enables bne (handled inside decode_pkg::decode).
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32,
    parameter int unsigned IMM_W  = 16
) (
    input logic           Clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam int unsigned AW    = $clog2(NREG);
    localparam int unsigned EXT_W = DATA_W - IMM_W;

    ctrl_t             ctrl_id;
    logic [AW-1:0]     rs_c, rt_c, rd_c;
    logic [DATA_W-1:0] rdata_x, rdata_y;
    logic [DATA_W-1:0] x_c, y_c, imm_c, br_target_c;
    logic              load_use_c, redirect_ok_c, x_eq_y_c;

    logic              valid_ex_q, valid_ex_d;
    ctrl_t             ctrl_ex_q, ctrl_ex_d;
    logic [DATA_W-1:0] x_ex_q, x_ex_d;
    logic [DATA_W-1:0] y_ex_q, y_ex_d;
    logic [DATA_W-1:0] imm_ex_q, imm_ex_d;
    logic [DATA_W-1:0] pc4_ex_q, pc4_ex_d;
    logic [AW-1:0]     rt_ex_q, rt_ex_d;
    logic [AW-1:0]     rd_ex_q, rd_ex_d;

    assign ctrl_id = decode(bus.ir_id[31:26], bus.ir_id[5:0]);

    // Register fields; jal reads the link-register slot as its rs.
    always_comb begin
        rs_c = AW'(bus.ir_id[25:21]);
        if (ctrl_id.link) begin
            rs_c = AW'(NREG - 1);
        end
        rt_c = AW'(bus.ir_id[20:16]);
        rd_c = AW'(bus.ir_id[15:11]);
    end

    reg_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_reg_file (
        .Clk       (Clk),
        .rst_n     (rst_n),
        .raddr_x_i (rs_c),
        .raddr_y_i (rt_c),
        .rdata_x_o (rdata_x),
        .rdata_y_o (rdata_y),
        .we_i      (bus.wb_we),
        .waddr_i   (bus.wb_addr),
        .wdata_i   (bus.wb_data)
    );

    // Operand forwarding; the reserved select code falls back to the register file.
    always_comb begin
        x_c = rdata_x;
        y_c = rdata_y;
        case (bus.fwd_sel_x)
            2'd1:    x_c = bus.fwd_exm;
            2'd2:    x_c = bus.fwd_mwb;
            default: x_c = rdata_x;
        endcase
        case (bus.fwd_sel_y)
            2'd1:    y_c = bus.fwd_exm;
            2'd2:    y_c = bus.fwd_mwb;
            default: y_c = rdata_y;
        endcase
    end

    assign imm_c       = {{EXT_W{bus.ir_id[IMM_W-1]}}, bus.ir_id[IMM_W-1:0]};
    assign br_target_c = bus.pc4_id + (imm_c << 2);
    assign x_eq_y_c    = (x_c == y_c);

    // A load in EX whose destination feeds this instruction must wait one cycle.
    assign load_use_c = valid_ex_q && ctrl_ex_q.mem_read && (rt_ex_q != '0) &&
                        ((rt_ex_q == rs_c) || ((rt_ex_q == rt_c) && ctrl_id.uses_rt));

    // Never redirect on stale operands or from a squashed instruction.
    assign redirect_ok_c = !(load_use_c || bus.flush);

    // ID/EX next state: stall holds, flush/load-use inserts a bubble, else load.
    always_comb begin
        valid_ex_d = valid_ex_q;
        ctrl_ex_d  = ctrl_ex_q;
        x_ex_d     = x_ex_q;
        y_ex_d     = y_ex_q;
        imm_ex_d   = imm_ex_q;
        pc4_ex_d   = pc4_ex_q;
        rt_ex_d    = rt_ex_q;
        rd_ex_d    = rd_ex_q;
        if (!bus.stall) begin
            if (bus.flush || load_use_c) begin
                valid_ex_d = 1'b0;
                ctrl_ex_d  = '0;
                x_ex_d     = '0;
                y_ex_d     = '0;
                imm_ex_d   = '0;
                pc4_ex_d   = '0;
                rt_ex_d    = '0;
                rd_ex_d    = '0;
            end else begin
                valid_ex_d = 1'b1;
                ctrl_ex_d  = ctrl_id;
                x_ex_d     = x_c;
                y_ex_d     = y_c;
                imm_ex_d   = imm_c;
                pc4_ex_d   = bus.pc4_id;
                rt_ex_d    = rt_c;
                rd_ex_d    = rd_c;
            end
        end
    end

    // ID/EX register with asynchronous clear.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_ex_q <= 1'b0;
            ctrl_ex_q  <= '0;
            x_ex_q     <= '0;
            y_ex_q     <= '0;
            imm_ex_q   <= '0;
            pc4_ex_q   <= '0;
            rt_ex_q    <= '0;
            rd_ex_q    <= '0;
        end else begin
            valid_ex_q <= valid_ex_d;
            ctrl_ex_q  <= ctrl_ex_d;
            x_ex_q     <= x_ex_d;
            y_ex_q     <= y_ex_d;
            imm_ex_q   <= imm_ex_d;
            pc4_ex_q   <= pc4_ex_d;
            rt_ex_q    <= rt_ex_d;
            rd_ex_q    <= rd_ex_d;
        end
    end

    assign bus.rs_id          = rs_c;
    assign bus.rt_id          = rt_c;
    assign bus.load_use_stall = load_use_c;
    assign bus.br_taken_id    = redirect_ok_c &&
                                ((ctrl_id.branch && x_eq_y_c) || (ctrl_id.branch_ne && !x_eq_y_c));
    assign bus.jump_id        = redirect_ok_c && ctrl_id.jump;
    assign bus.jr_id          = redirect_ok_c && ctrl_id.jump_reg;
    assign bus.br_target_id   = br_target_c;
    assign bus.jr_target_id   = x_c;
    assign bus.ctrl_ex        = ctrl_ex_q;
    assign bus.valid_ex       = valid_ex_q;
    assign bus.x_ex           = x_ex_q;
    assign bus.y_ex           = y_ex_q;
    assign bus.imm_ex         = imm_ex_q;
    assign bus.pc4_ex         = pc4_ex_q;
    assign bus.rt_ex          = rt_ex_q;
    assign bus.rd_ex          = rd_ex_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed pins plus randomized traffic checked against a behavioural model.
module tb_decode_stage;
    import decode_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    localparam int K_ADD = 0, K_SUB = 1, K_AND = 2, K_OR = 3, K_SLT = 4, K_JR = 5,
                   K_LW = 6, K_SW = 7, K_BEQ = 8, K_BNE = 9, K_ADDI = 10, K_J = 11,
                   K_JAL = 12, K_BADOP = 13, K_BADFN = 14, K_NUM = 15;

    logic Clk = 1'b0;
    logic rst_n;
    always #5 Clk = ~Clk;

    decode_stage_if #(.DATA_W(DATA_W), .NREG(NREG)) bus ();

    decode_stage #(.DATA_W(DATA_W), .NREG(NREG), .IMM_W(16)) dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec  = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int cur_kind;

    // Behavioural model state
    logic [31:0] m_regs [NREG];
    logic        m_valid;
    ctrl_t       m_ctrl;
    logic [31:0] m_x, m_y, m_imm, m_pc4;
    logic [4:0]  m_rt, m_rd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // What each instruction class must produce on the control bundle.
    function automatic ctrl_t exp_ctrl(input int k);
        ctrl_t c;
        c = '0;
        case (k)
            K_ADD:  begin c.reg_write = 1; c.reg_dst = 1; c.uses_rt = 1; c.alu_op = ALU_ADD; end
            K_SUB:  begin c.reg_write = 1; c.reg_dst = 1; c.uses_rt = 1; c.alu_op = ALU_SUB; end
            K_AND:  begin c.reg_write = 1; c.reg_dst = 1; c.uses_rt = 1; c.alu_op = ALU_AND; end
            K_OR:   begin c.reg_write = 1; c.reg_dst = 1; c.uses_rt = 1; c.alu_op = ALU_OR;  end
            K_SLT:  begin c.reg_write = 1; c.reg_dst = 1; c.uses_rt = 1; c.alu_op = ALU_SLT; end
            K_JR:   c.jump_reg = 1;
            K_LW:   begin c.reg_write = 1; c.mem_read = 1; c.mem_to_reg = 1; c.alu_src = 1; c.alu_op = ALU_ADD; end
            K_SW:   begin c.mem_write = 1; c.alu_src = 1; c.uses_rt = 1; c.alu_op = ALU_ADD; end
            K_BEQ:  begin c.branch = 1; c.uses_rt = 1; c.alu_op = ALU_SUB; end
`ifdef DECODE_BNE_EN
            K_BNE:  begin c.branch_ne = 1; c.uses_rt = 1; c.alu_op = ALU_SUB; end
`endif
            K_ADDI: begin c.reg_write = 1; c.alu_src = 1; c.alu_op = ALU_ADD; end
            K_J:    c.jump = 1;
            K_JAL:  begin c.jump = 1; c.link = 1; c.reg_write = 1; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] rd_reg(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (bus.wb_we && (bus.wb_addr == a)) return bus.wb_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return bus.fwd_exm;
        if (sel == 2'd2) return bus.fwd_mwb;
        return rf;
    endfunction

    task automatic set_instr(input int k, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [15:0] imm);
        cur_kind = k;
        case (k)
            K_ADD:   bus.ir_id = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            K_SUB:   bus.ir_id = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            K_AND:   bus.ir_id = {OP_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            K_OR:    bus.ir_id = {OP_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            K_SLT:   bus.ir_id = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            K_JR:    bus.ir_id = {OP_RTYPE, rs, 15'd0, FN_JR};
            K_LW:    bus.ir_id = {OP_LW, rs, rt, imm};
            K_SW:    bus.ir_id = {OP_SW, rs, rt, imm};
            K_BEQ:   bus.ir_id = {OP_BEQ, rs, rt, imm};
            K_BNE:   bus.ir_id = {OP_BNE, rs, rt, imm};
            K_ADDI:  bus.ir_id = {OP_ADDI, rs, rt, imm};
            K_J:     bus.ir_id = {OP_J, rs, rt, imm};
            K_JAL:   bus.ir_id = {OP_JAL, rs, rt, imm};
            K_BADOP: bus.ir_id = {6'h3F, rs, rt, imm};
            default: bus.ir_id = {OP_RTYPE, rs, rt, rd, 5'd0, 6'h3F};
        endcase
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Compare process: on every falling edge check all outputs, then advance the model.
    initial begin : model
        ctrl_t       c;
        logic [4:0]  rs, rt;
        logic [31:0] xv, yv, simm;
        logic        lus, gate, eq;
        forever begin
            @(negedge Clk);
            if (!rst_n) begin
                for (int i = 0; i < NREG; i++) m_regs[i] = '0;
                m_valid = 1'b0; m_ctrl = '0; m_x = '0; m_y = '0;
                m_imm = '0; m_pc4 = '0; m_rt = '0; m_rd = '0;
            end
            n_vec++;
            chk("valid_ex", 32'(bus.valid_ex), 32'(m_valid));
            chk("ctrl_ex",  32'(bus.ctrl_ex),  32'(m_ctrl));
            chk("x_ex",     bus.x_ex,   m_x);
            chk("y_ex",     bus.y_ex,   m_y);
            chk("imm_ex",   bus.imm_ex, m_imm);
            chk("pc4_ex",   bus.pc4_ex, m_pc4);
            chk("rt_ex",    32'(bus.rt_ex), 32'(m_rt));
            chk("rd_ex",    32'(bus.rd_ex), 32'(m_rd));

            c    = exp_ctrl(cur_kind);
            rs   = (cur_kind == K_JAL) ? 5'd31 : bus.ir_id[25:21];
            rt   = bus.ir_id[20:16];
            xv   = pick(bus.fwd_sel_x, rd_reg(rs));
            yv   = pick(bus.fwd_sel_y, rd_reg(rt));
            simm = {{16{bus.ir_id[15]}}, bus.ir_id[15:0]};
            eq   = (xv == yv);
            lus  = m_valid && m_ctrl.mem_read && (m_rt != 5'd0) &&
                   ((m_rt == rs) || ((m_rt == rt) && c.uses_rt));
            gate = lus || bus.flush;

            chk("rs_id", 32'(bus.rs_id), 32'(rs));
            chk("rt_id", 32'(bus.rt_id), 32'(rt));
            chk("load_use_stall", 32'(bus.load_use_stall), 32'(lus));
            chk("br_taken_id", 32'(bus.br_taken_id),
                32'(!gate && ((c.branch && eq) || (c.branch_ne && !eq))));
            chk("jump_id", 32'(bus.jump_id), 32'(!gate && c.jump));
            chk("jr_id", 32'(bus.jr_id), 32'(!gate && c.jump_reg));
            chk("br_target_id", bus.br_target_id, bus.pc4_id + (simm << 2));
            chk("jr_target_id", bus.jr_target_id, xv);

            if (rst_n) begin
                if (!bus.stall) begin
                    if (gate) begin
                        m_valid = 1'b0; m_ctrl = '0; m_x = '0; m_y = '0;
                        m_imm = '0; m_pc4 = '0; m_rt = '0; m_rd = '0;
                    end else begin
                        m_valid = 1'b1; m_ctrl = c; m_x = xv; m_y = yv;
                        m_imm = simm; m_pc4 = bus.pc4_id;
                        m_rt = rt; m_rd = bus.ir_id[15:11];
                    end
                end
                if (bus.wb_we && (bus.wb_addr != 5'd0)) m_regs[bus.wb_addr] = bus.wb_data;
            end
        end
    end

    // Driver with hand-computed literal pins, then randomized traffic.
    initial begin : drive
        rst_n = 1'b1;
        bus.stall = 0; bus.flush = 0; bus.pc4_id = '0;
        bus.wb_we = 0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.fwd_sel_x = 0; bus.fwd_sel_y = 0; bus.fwd_exm = '0; bus.fwd_mwb = '0;
        set_instr(K_BADFN, 5'd0, 5'd0, 5'd0, 16'd0);
        #2 rst_n = 1'b0;
        step();
        chk("reset valid_ex", 32'(bus.valid_ex), 32'd0);
        chk("reset ctrl_ex", 32'(bus.ctrl_ex), 32'd0);
        chk("reset x_ex", bus.x_ex, 32'd0);
        step();
        rst_n = 1'b1;

        // Write-through and r0
        bus.wb_we = 1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEAD_BEEF;
        set_instr(K_ADD, 5'd5, 5'd0, 5'd1, 16'd0);
        step();
        chk("wt x_ex", bus.x_ex, 32'hDEAD_BEEF);
        chk("wt valid_ex", 32'(bus.valid_ex), 32'd1);
        bus.wb_addr = 5'd0; bus.wb_data = 32'h0000_1234;
        set_instr(K_ADD, 5'd0, 5'd0, 5'd1, 16'd0);
        step();
        chk("r0 bypass x_ex", bus.x_ex, 32'd0);
        bus.wb_we = 0;
        set_instr(K_ADD, 5'd5, 5'd0, 5'd1, 16'd0);
        step();
        chk("r5 stored x_ex", bus.x_ex, 32'hDEAD_BEEF);
        chk("r0 stored y_ex", bus.y_ex, 32'd0);

        // Load-use
        set_instr(K_LW, 5'd3, 5'd2, 5'd0, 16'd0);
        step();
        chk("lw rt_ex", 32'(bus.rt_ex), 32'd2);
        set_instr(K_ADD, 5'd2, 5'd2, 5'd4, 16'd0);
        bus.fwd_sel_x = 2; bus.fwd_mwb = 32'hCAFE_0001;
        #1 chk("lu stall", 32'(bus.load_use_stall), 32'd1);
        step();
        chk("lu bubble", 32'(bus.valid_ex), 32'd0);
        #1 chk("lu released", 32'(bus.load_use_stall), 32'd0);
        step();
        chk("lu add valid", 32'(bus.valid_ex), 32'd1);
        chk("lu add x_ex", bus.x_ex, 32'hCAFE_0001);

        // Branch
        bus.fwd_sel_x = 1; bus.fwd_sel_y = 1; bus.fwd_exm = 32'd7; bus.pc4_id = 32'h100;
        set_instr(K_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFE);
        #1 chk("beq taken", 32'(bus.br_taken_id), 32'd1);
        chk("beq target", bus.br_target_id, 32'h0000_00F8);
        set_instr(K_BNE, 5'd1, 5'd2, 5'd0, 16'hFFFE);
        #1 chk("bne not taken", 32'(bus.br_taken_id), 32'd0);
        set_instr(K_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFE);
        bus.flush = 1;
        #1 chk("beq gated", 32'(bus.br_taken_id), 32'd0);
        bus.flush = 0;
        step();

        // Priority
        bus.fwd_sel_x = 0; bus.fwd_sel_y = 0;
        set_instr(K_ADD, 5'd5, 5'd0, 5'd3, 16'd0);
        step();
        chk("pri load x_ex", bus.x_ex, 32'hDEAD_BEEF);
        bus.stall = 1; bus.flush = 1;
        set_instr(K_SUB, 5'd0, 5'd0, 5'd0, 16'd0);
        step();
        chk("pri hold valid", 32'(bus.valid_ex), 32'd1);
        chk("pri hold x_ex", bus.x_ex, 32'hDEAD_BEEF);
        chk("pri hold rd_ex", 32'(bus.rd_ex), 32'd3);
        bus.stall = 0;
        step();
        chk("flush valid", 32'(bus.valid_ex), 32'd0);
        chk("flush ctrl", 32'(bus.ctrl_ex), 32'd0);
        bus.flush = 0;

        // jal
        bus.pc4_id = 32'h2000;
        set_instr(K_JAL, 5'd4, 5'd9, 5'd0, 16'h0040);
        #1 chk("jal rs_id", 32'(bus.rs_id), 32'd31);
        chk("jal jump_id", 32'(bus.jump_id), 32'd1);
        step();
        chk("jal pc4_ex", bus.pc4_ex, 32'h2000);

        // Asynchronous reset mid-run
        rst_n = 1'b0;
        #1 chk("async valid_ex", 32'(bus.valid_ex), 32'd0);
        chk("async pc4_ex", bus.pc4_ex, 32'd0);
        step();
        rst_n = 1'b1;

        // jr
        bus.fwd_sel_x = 1; bus.fwd_exm = 32'h400;
        set_instr(K_JR, 5'd7, 5'd0, 5'd0, 16'd0);
        #1 chk("jr_id", 32'(bus.jr_id), 32'd1);
        chk("jr_target", bus.jr_target_id, 32'h400);
        bus.flush = 1;
        #1 chk("jr gated", 32'(bus.jr_id), 32'd0);
        bus.flush = 0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n     = ($urandom_range(0, 299) != 0);
            bus.stall = ($urandom_range(0, 9) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            bus.pc4_id = $urandom() & 32'hFFFF_FFFC;
            bus.wb_we   = ($urandom_range(0, 1) == 1);
            bus.wb_addr = 5'($urandom_range(0, 7));
            bus.wb_data = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
            bus.fwd_sel_x = 2'($urandom_range(0, 2));
            bus.fwd_sel_y = 2'($urandom_range(0, 2));
            bus.fwd_exm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
            bus.fwd_mwb = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom();
            set_instr($urandom_range(0, K_NUM - 1), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 16'($urandom()));
        end
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
